// File: rtl/jtpang_pkg.sv
// Shared types and defaults for the Pang object DMA sequencer.
package jtpang_pkg;

  localparam int DMA_LEN_DEF = 512;
  localparam int DMA_AW_DEF  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_REQ,
    ST_XFER,
    ST_REL
  } dma_st_t;

endpackage

// File: rtl/jtpang_objdma.sv
// Object DMA: takes the Z80 bus and copies object RAM into the object line buffer.
// Optional feature: define JTPANG_DMA_VBLANK_EN to hold transfers until vertical blank.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer, waiting for a dma_go rising edge
// WAIT_VB  | trigger accepted, waiting for LVBL low (vblank build only)
// REQ      | busrq high, waiting for busak_n low
// XFER     | one source read and one buffer write per cen
// REL      | busrq low, waiting for the CPU to drop busak_n
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int              AW       = DMA_AW_DEF,
  parameter int              LEN      = DMA_LEN_DEF,
  parameter logic [AW-1:0]   SRC_BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_data,
  output logic [AW-1:0] dst_addr,
  output logic [7:0]    dst_data,
  output logic          dst_we,
  output logic          busy
);

  localparam logic [AW:0]   CNT_LAST = (AW+1)'(LEN);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  dma_st_t       st_q, st_d;
  logic          go_q, go_d;
  logic          pend_q, pend_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          busrq_q, busrq_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [7:0]    dst_data_q, dst_data_d;
  logic          dst_we_q, dst_we_d;

  logic go_rise;
  logic start;

  assign go_rise = cen & dma_go & ~go_q;

  always_comb begin
    st_d       = st_q;
    go_d       = go_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    busrq_d    = busrq_q;
    busy_d     = busy_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_we_d   = 1'b0;
    start      = 1'b0;

    if (cen) begin
      go_d = dma_go;
      // Only one retrigger is remembered while a transfer is in flight
      if (busy_q && go_rise) pend_d = 1'b1;

      case (st_q)
        ST_IDLE: begin
          if (go_rise) start = 1'b1;
        end
        ST_WAIT_VB: begin
          if (!LVBL) begin
            st_d    = ST_REQ;
            busrq_d = 1'b1;
          end
        end
        ST_REQ: begin
          if (!busak_n) begin
            st_d  = ST_XFER;
            cnt_d = '0;
          end
        end
        ST_XFER: begin
          if (busak_n) begin
            // CPU took the bus back: stop without another write
            st_d    = ST_REL;
            busrq_d = 1'b0;
          end else begin
            if (cnt_q != '0) begin
              dst_addr_d = cnt_q[AW-1:0] - ADDR_ONE;
              dst_data_d = src_data;
              dst_we_d   = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
              st_d = ST_REL;
            end else begin
              src_addr_d = SRC_BASE + cnt_q[AW-1:0];
              cnt_d      = cnt_q + CNT_ONE;
            end
          end
        end
        ST_REL: begin
          busrq_d = 1'b0;
          if (busak_n) begin
            if (pend_q || go_rise) begin
              start  = 1'b1;
              pend_d = 1'b0;
            end else begin
              st_d   = ST_IDLE;
              busy_d = 1'b0;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase

      if (start) begin
        busy_d = 1'b1;
`ifdef JTPANG_DMA_VBLANK_EN
        st_d = ST_WAIT_VB;
`else
        st_d    = ST_REQ;
        busrq_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      go_q       <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      go_q       <= go_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_we_q   <= dst_we_d;
    end
  end

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma with a write-sequence model and a delayed bus acknowledge.
module tb_jtpang_objdma;

  localparam int         AW   = 12;
  localparam int         LEN  = 512;
  localparam logic [11:0] BASE = 12'hF00;
`ifdef JTPANG_DMA_VBLANK_EN
  localparam int TRIG_LAT = 2;
`else
  localparam int TRIG_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic          LVBL;
  logic          dma_go;
  logic          busrq;
  logic          busak_n;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = 8'h00;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_data;
  logic          dst_we;
  logic          busy;

  int n_checks = 0;
  int n_errs   = 0;
  int total_wr = 0;
  int ep_q[$];
  logic [7:0] got_data [LEN];
  logic [7:0] mem [4096];
  logic [1:0] cdiv = 2'd0;
  logic [2:0] ack_sr = 3'b000;
  logic       force_hi;

  jtpang_objdma #(.AW(AW), .LEN(LEN), .SRC_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .cen(cen), .LVBL(LVBL), .dma_go(dma_go),
    .busrq(busrq), .busak_n(busak_n), .src_addr(src_addr), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cdiv <= cdiv + 2'd1;
  assign cen = (cdiv == 2'd3);

  always @(posedge clk) src_data <= mem[src_addr];

  always @(posedge clk) if (cen) ack_sr <= {ack_sr[1:0], busrq};
  assign busak_n = force_hi | ~ack_sr[2];

  function automatic logic [7:0] src_byte(input int a);
    logic [11:0] ad;
    ad = a[11:0];
    return ad[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step_cen();
    do @(negedge clk); while (!cen);
    @(negedge clk);
  endtask

  task automatic trigger(input string nm);
    dma_go = 1'b1;
    repeat (TRIG_LAT) step_cen();
    dma_go = 1'b0;
    chk(nm, busrq, 1);
    chk({nm, "_busy"}, busy, 1);
  endtask

  task automatic wait_we_addr(input int a, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (dst_we && dst_addr == a[AW-1:0]) ok = 1'b1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_eps(input int n, input string nm);
    for (int i = 0; i < 40000 && ep_q.size() < n; i++) @(negedge clk);
    chk(nm, ep_q.size(), n);
  endtask

  task automatic pop_ep(input int exp_len, input string nm);
    int v;
    v = -1;
    if (ep_q.size() > 0) v = ep_q.pop_front();
    chk(nm, v, exp_len);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk(nm, busy, 0);
  endtask

  // Model: every bus tenure writes indices 0,1,2,... with dst[k] = src[(BASE+k) mod 4096]
  task automatic monitor();
    int ep;
    ep = 0;
    forever begin
      @(negedge clk);
      if (busrq) chk("busy_with_busrq", busy, 1);
      if (dst_we) begin
        chk("wr_addr", dst_addr, ep);
        chk("wr_data", dst_data, src_byte(int'(BASE) + ep));
        chk("wr_inside_bus", busrq, 1);
        got_data[dst_addr[8:0]] = dst_data;
        ep++;
        total_wr++;
      end else if (!busrq && ep != 0) begin
        ep_q.push_back(ep);
        ep = 0;
      end
    end
  endtask

  initial begin
    bit flag;
    int sa;
    int wr0;

    for (int i = 0; i < 4096; i++) mem[i] = src_byte(i);
    rst = 1'b1; dma_go = 1'b0; LVBL = 1'b0; force_hi = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busrq", busrq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dst_we", dst_we, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_dst_data", dst_data, 0);
    rst = 1'b0;
    repeat (3) step_cen();

    // basic transfer
    trigger("basic_trig_busrq");
    wait_we_addr(LEN - 1, "basic_last_write");
    chk("basic_last_busrq_held", busrq, 1);
    step_cen();
    chk("basic_busrq_fall", busrq, 0);
    wait_eps(1, "basic_episode");
    pop_ep(LEN, "basic_len");
    wait_idle("basic_idle");
    chk("pin_data_012", got_data[9'h012], 8'h48);
    chk("pin_data_0ff", got_data[9'h0FF], 8'hA5);
    chk("pin_data_1a5", got_data[9'h1A5], 8'hFF);
    repeat (3) step_cen();

    // acknowledge stall
    force_hi = 1'b1;
    trigger("stall_trig_busrq");
    sa = int'(src_addr);
    wr0 = total_wr;
    flag = 1'b0;
    repeat (100) begin
      step_cen();
      if (int'(src_addr) != sa) flag = 1'b1;
    end
    chk("stall_src_hold", flag, 0);
    chk("stall_no_we", total_wr - wr0, 0);
    force_hi = 1'b0;
    step_cen();
    chk("ack_src_not_yet", src_addr, sa);
    step_cen();
    chk("ack_first_src", src_addr, BASE);
    chk("ack_no_we_yet", dst_we, 0);
    step_cen();
    chk("ack_first_we", dst_we, 1);
    chk("ack_first_addr", dst_addr, 0);
    wait_eps(1, "stall_episode");
    pop_ep(LEN, "stall_len");
    wait_idle("stall_idle");
    repeat (3) step_cen();

    // retrigger during transfer
    trigger("retrig_trig_busrq");
    wait_we_addr(10, "retrig_reach_10");
    repeat (3) begin
      dma_go = 1'b1; step_cen();
      dma_go = 1'b0; step_cen();
    end
    flag = 1'b0;
    for (int i = 0; i < 40000 && ep_q.size() < 2; i++) begin
      @(negedge clk);
      if (!busy) flag = 1'b1;
    end
    chk("retrig_two_eps", ep_q.size(), 2);
    pop_ep(LEN, "retrig_len_1");
    pop_ep(LEN, "retrig_len_2");
    chk("retrig_busy_held", flag, 0);
    wait_idle("retrig_idle");
    flag = 1'b0;
    repeat (30) begin
      step_cen();
      if (busrq || busy) flag = 1'b1;
    end
    chk("retrig_no_third", flag, 0);

    // abort at byte 100
    trigger("abort_trig_busrq");
    wait_we_addr(100, "abort_reach_100");
    force_hi = 1'b1;
    step_cen();
    chk("abort_busrq_low", busrq, 0);
    step_cen();
    chk("abort_idle", busy, 0);
    wr0 = total_wr;
    repeat (10) step_cen();
    chk("abort_no_more_we", total_wr - wr0, 0);
    wait_eps(1, "abort_episode");
    pop_ep(101, "abort_len");
    force_hi = 1'b0;
    repeat (5) step_cen();

    // reset mid-transfer at byte 50
    trigger("rst_trig_busrq");
    wait_we_addr(50, "rst_reach_50");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busrq", busrq, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dst_we", dst_we, 0);
    rst = 1'b0;
    wait_eps(1, "midrst_episode");
    pop_ep(51, "midrst_len");
    repeat (5) step_cen();
    trigger("postrst_trig_busrq");
    wait_eps(1, "postrst_episode");
    pop_ep(LEN, "postrst_len");
    wait_idle("postrst_idle");

`ifdef JTPANG_DMA_VBLANK_EN
    // trigger outside vblank
    repeat (3) step_cen();
    LVBL = 1'b1;
    dma_go = 1'b1; step_cen(); dma_go = 1'b0;
    flag = 1'b0;
    repeat (20) begin
      step_cen();
      if (busrq) flag = 1'b1;
    end
    chk("vb_busrq_held_low", flag, 0);
    chk("vb_busy", busy, 1);
    LVBL = 1'b0;
    step_cen();
    chk("vb_busrq_rise", busrq, 1);
    wait_eps(1, "vb_episode");
    pop_ep(LEN, "vb_len");
    wait_idle("vb_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/jtpang_objdma.md
# jtpang_objdma

Object DMA sequencer for the Pang core. On a CPU DMA trigger it requests the main Z80 bus, waits for bus acknowledge, copies a fixed-length block of object attribute RAM into the video object line buffer one byte per pixel clock enable, then releases the bus. It sits between the main CPU interface (`dma_go`, `busrq`/`busak_n`) and the object renderer inside the video block.

## Interface
Parameters:
- `AW`, 12: source/destination byte address width.
- `LEN`, 512: bytes per transfer; must be a power of two, at most 2^AW.
- `SRC_BASE`, 12'h000: first source address in object RAM.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cen`  in  1  pixel clock enable (6 MHz); all state advances only when high, except reset.
- `LVBL`  in  1  vertical blank, active low.
- `dma_go`  in  1  CPU trigger; sampled on `cen` and rising-edge detected.
- `busrq`  out  1  bus request to the CPU, active high.
- `busak_n`  in  1  bus acknowledge from the CPU, active low.
- `src_addr`  out  AW  object RAM read address.
- `src_data`  in  8  object RAM read data, valid one `cen` after the address.
- `dst_addr`  out  AW  object buffer write address.
- `dst_data`  out  8  object buffer write data.
- `dst_we`  out  1  object buffer write strobe, one `clk` wide, coincident with `cen`.
- `busy`  out  1  high from trigger acceptance until return to IDLE.

## Operation
- States: IDLE, WAIT_VB, REQ, XFER, REL.
- IDLE: a rising edge on `dma_go` goes to WAIT_VB if the macro is defined, otherwise to REQ. `busy` is set.
- WAIT_VB: hold until `LVBL` = 0, then go to REQ.
- REQ: `busrq` = 1. When `busak_n` = 0 is sampled, clear the byte counter and go to XFER.
- XFER: `src_addr` = `SRC_BASE` + cnt. One cycle later, `dst_addr` = cnt-1 and `dst_data` = `src_data`, with `dst_we` pulsed.
  - The counter is AW+1 bits wide. After the write with cnt-1 = LEN-1 (LEN writes in total), go to REL.
  - `src_addr` wraps modulo 2^AW.
- REL: drop `busrq`. Wait for `busak_n` = 1, then go to IDLE and clear `busy`.
- A trigger edge while `busy` = 1 sets a single pending flag. Further edges are lost. On REL→IDLE, a set pending flag starts a new transfer immediately, skipping IDLE dwell, and the flag clears.
- If `busak_n` rises during XFER (CPU reclaims the bus), abort to REL. No further `dst_we` pulses occur.

## Timing
- Reset values: `busrq` = 0, `dst_we` = 0, `busy` = 0; all addresses and data 0; state IDLE; pending flag 0.
- Reset mid-transfer: all outputs reach reset values on the first `clk` with `rst` high.
- Trigger to `busrq`: 1 `cen` (no macro).
- `busak_n` low to first `src_addr`: 1 `cen`. First `dst_we`: 2 `cen` after acknowledge.
- XFER lasts LEN+1 `cen`. `busrq` falls 1 `cen` after the last `dst_we`.
- `dma_go` held high is a single trigger. A new trigger needs a low sample in between.

## Configuration
- `JTPANG_DMA_VBLANK_EN` defined: a trigger outside vertical blank waits in WAIT_VB until `LVBL` = 0, so the object buffer is never written while it is displayed.
- Not defined: WAIT_VB is unreachable and `LVBL` is ignored. Transfers start 1 `cen` after the trigger.

## Structure
- Shared package `jtpang_pkg` holds:
  - the state enum type `dma_st_t`;
  - constants `DMA_LEN_DEF` = 512 and `DMA_AW_DEF` = 12.
- No sub-module is needed. The edge detector, counter and FSM stay in one module of roughly 150 lines.

## Test plan
- Basic transfer, no macro: fill source with addr[7:0] ^ 8'h5A. Pulse `dma_go`, tie `busak_n` = `~busrq` with a 3-`cen` delay. Expect 512 `dst_we` pulses, destination matching the source, and `busrq` low 1 `cen` after the last write.
- Acknowledge stall: hold `busak_n` = 1 for 100 `cen` after `busrq`. Expect no `src_addr` change and no `dst_we` until acknowledge; then the 2-`cen` latency to the first write.
- Retrigger: pulse `dma_go` three times during XFER. Expect exactly two complete transfers, and `busy` low only after the second.
- Abort: raise `busak_n` at byte 100. Expect no writes after byte 100, `busrq` low next `cen`, then IDLE.
- Reset mid-XFER at byte 50: `busrq`, `busy` and `dst_we` are 0 on the next `clk`. A new trigger after reset completes a full 512-byte copy.
- With `JTPANG_DMA_VBLANK_EN`: trigger while `LVBL` = 1. Expect `busrq` held low until `LVBL` falls, then asserted 1 `cen` later.
